// File: rtl/down_cascade_stage.sv
// Cascade stage behind the 4-bit down counter: borrow detect, upper count,
// terminal count in one-shot or auto-reload mode, and stalled-source flag.
module down_cascade_stage #(
   parameter int HI_W      = 4,
   parameter int STALL_CYC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      cnt_in,
   input  logic            en,
   input  logic            start,
   input  logic            mode_reload,
   input  logic [HI_W-1:0] reload_hi,
   input  logic            clr_done,
   output logic [HI_W+3:0] count_out,
   output logic            borrow,
   output logic            tc,
   output logic            done,
   output logic            stall,
   output logic            busy
);

   localparam int SC_W =
      (STALL_CYC > 0) ? $clog2(STALL_CYC + 1) : 1;
   localparam logic [SC_W-1:0] SC_MAX =
      SC_W'(STALL_CYC);
   localparam logic [SC_W-1:0] SC_ONE =
      SC_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t          state;
   logic [HI_W-1:0] hi_cnt;
   logic [3:0]      cnt_q;
   logic            valid_q;
   logic [SC_W-1:0] stall_cnt;

   logic borrow_det;
   logic same;
   logic hi_zero;

   // Only a true 0 -> F step counts as a wrap.
   assign borrow_det = valid_q
                    && (cnt_q == 4'h0)
                    && (cnt_in == 4'hF);
   assign same      = valid_q && (cnt_in == cnt_q);
   assign hi_zero   = (hi_cnt == '0);

   assign count_out = {hi_cnt, cnt_q};
   assign busy      = (state == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         hi_cnt    <= '0;
         cnt_q     <= 4'h0;
         valid_q   <= 1'b0;
         stall_cnt <= '0;
         borrow    <= 1'b0;
         tc        <= 1'b0;
         done      <= 1'b0;
         stall     <= 1'b0;
      end else begin
         cnt_q   <= cnt_in;
         valid_q <= 1'b1;
         borrow  <= 1'b0;
         tc      <= 1'b0;
         if (clr_done)
            done <= 1'b0;
         if (start) begin
            hi_cnt    <= reload_hi;
            state     <= RUN;
            done      <= 1'b0;
            stall     <= 1'b0;
            stall_cnt <= '0;
         end else if (state == RUN && en) begin
            if (borrow_det) begin
               borrow <= 1'b1;
               if (!hi_zero) begin
                  hi_cnt <= hi_cnt - HI_W'(1);
               end else begin
                  tc <= 1'b1;
                  if (mode_reload) begin
                     hi_cnt <= reload_hi;
                  end else begin
                     state <= FIN;
                     done  <= 1'b1;
                  end
               end
            end
            // Saturating run length of unchanged samples.
            if (STALL_CYC > 0) begin
               if (same) begin
                  if (stall_cnt != SC_MAX)
                     stall_cnt <= stall_cnt + SC_ONE;
                  if (stall_cnt >= SC_MAX - SC_ONE)
                     stall <= 1'b1;
               end else begin
                  stall_cnt <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_down_cascade_stage.sv
// Bench for down_cascade_stage: fixed vector table, stall and reset
// sequences, then random traffic against a behavioural model.
module tb_down_cascade_stage;

   localparam int HI_W  = 4;
   localparam int STALL = 8;

   logic            clk;
   logic            rst;
   logic [3:0]      cnt_in;
   logic            en;
   logic            start;
   logic            mode_reload;
   logic [HI_W-1:0] reload_hi;
   logic            clr_done;
   logic [HI_W+3:0] count_out;
   logic            borrow;
   logic            tc;
   logic            done;
   logic            stall;
   logic            busy;

   down_cascade_stage #(
      .HI_W      (HI_W),
      .STALL_CYC (STALL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cnt_in      (cnt_in),
      .en          (en),
      .start       (start),
      .mode_reload (mode_reload),
      .reload_hi   (reload_hi),
      .clr_done    (clr_done),
      .count_out   (count_out),
      .borrow      (borrow),
      .tc          (tc),
      .done        (done),
      .stall       (stall),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] cnt;
      bit         en;
      bit         start;
      bit         mode;
      logic [3:0] rl;
      bit         clr;
      logic [7:0] cout;
      bit         b;
      bit         t;
      bit         d;
      bit         s;
      bit         y;
   } vec_t;

   vec_t tbl [21];

   int vectors = 0;
   int errors  = 0;

   // Behavioural model: plain integers and flags.
   int m_hi;
   int m_prev;
   bit m_have_prev;
   bit m_running;
   bit m_finished;
   bit m_done;
   bit m_stall;
   int m_same_run;
   bit e_borrow;
   bit e_tc;

   function automatic logic [12:0] pack_dut();
      return {count_out, borrow, tc, done, stall, busy};
   endfunction

   task automatic check(input string name,
                        input logic [12:0] act,
                        input logic [12:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hi        = 0;
      m_prev      = 0;
      m_have_prev = 0;
      m_running   = 0;
      m_finished  = 0;
      m_done      = 0;
      m_stall     = 0;
      m_same_run  = 0;
      e_borrow    = 0;
      e_tc        = 0;
   endtask

   task automatic model_step();
      bit wrap;
      wrap = m_have_prev && m_prev == 0 && cnt_in == 4'hF;
      e_borrow = 0;
      e_tc     = 0;
      if (start) begin
         m_hi       = reload_hi;
         m_running  = 1;
         m_finished = 0;
         m_done     = 0;
         m_stall    = 0;
         m_same_run = 0;
      end else begin
         if (clr_done) m_done = 0;
         if (m_running && en) begin
            if (wrap) begin
               e_borrow = 1;
               if (m_hi > 0) begin
                  m_hi = m_hi - 1;
               end else begin
                  e_tc = 1;
                  if (mode_reload) begin
                     m_hi = reload_hi;
                  end else begin
                     m_running  = 0;
                     m_finished = 1;
                     m_done     = 1;
                  end
               end
            end
            if (m_have_prev && int'(cnt_in) == m_prev) begin
               if (m_same_run < STALL) m_same_run++;
            end else begin
               m_same_run = 0;
            end
            if (STALL > 0 && m_same_run >= STALL)
               m_stall = 1;
         end
      end
      m_prev      = int'(cnt_in);
      m_have_prev = 1;
   endtask

   function automatic logic [12:0] pack_model();
      logic [7:0] c;
      c = {m_hi[3:0], m_prev[3:0]};
      return {c, e_borrow, e_tc, m_done, m_stall, m_running};
   endfunction

   task automatic step(input bit use_model, input string name);
      model_step();
      @(posedge clk);
      #1;
      if (use_model) check(name, pack_dut(), pack_model());
   endtask

   task automatic drive(input logic [3:0] c, input bit e,
                        input bit s, input bit m,
                        input logic [3:0] r, input bit cl);
      cnt_in      = c;
      en          = e;
      start       = s;
      mode_reload = m;
      reload_hi   = r;
      clr_done    = cl;
   endtask

   initial begin
      logic [3:0] cur;
      int hold_left;
      int r;

      tbl[0]  = '{4'h5,1,1,0,4'd2,0,8'h25,0,0,0,0,1};
      tbl[1]  = '{4'h3,1,0,0,4'd2,0,8'h23,0,0,0,0,1};
      tbl[2]  = '{4'hF,1,0,0,4'd2,0,8'h2F,0,0,0,0,1};
      tbl[3]  = '{4'h0,1,0,0,4'd2,0,8'h20,0,0,0,0,1};
      tbl[4]  = '{4'hF,1,0,0,4'd2,0,8'h1F,1,0,0,0,1};
      tbl[5]  = '{4'h0,1,0,0,4'd2,0,8'h10,0,0,0,0,1};
      tbl[6]  = '{4'hF,0,0,0,4'd2,0,8'h1F,0,0,0,0,1};
      tbl[7]  = '{4'h0,1,0,0,4'd2,0,8'h10,0,0,0,0,1};
      tbl[8]  = '{4'hF,1,0,0,4'd2,0,8'h0F,1,0,0,0,1};
      tbl[9]  = '{4'h0,1,0,0,4'd2,0,8'h00,0,0,0,0,1};
      tbl[10] = '{4'hF,1,0,0,4'd2,0,8'h0F,1,1,1,0,0};
      tbl[11] = '{4'h0,1,0,0,4'd2,0,8'h00,0,0,1,0,0};
      tbl[12] = '{4'hF,1,0,0,4'd2,0,8'h0F,0,0,1,0,0};
      tbl[13] = '{4'h0,1,0,0,4'd2,1,8'h00,0,0,0,0,0};
      tbl[14] = '{4'hF,1,1,1,4'd1,0,8'h1F,0,0,0,0,1};
      tbl[15] = '{4'h0,1,0,1,4'd1,0,8'h10,0,0,0,0,1};
      tbl[16] = '{4'hF,1,0,1,4'd1,0,8'h0F,1,0,0,0,1};
      tbl[17] = '{4'h0,1,0,1,4'd1,0,8'h00,0,0,0,0,1};
      tbl[18] = '{4'hF,1,0,1,4'd1,0,8'h1F,1,1,0,0,1};
      tbl[19] = '{4'h0,1,0,1,4'd1,0,8'h10,0,0,0,0,1};
      tbl[20] = '{4'hF,1,1,1,4'd3,0,8'h3F,0,0,0,0,1};

      rst = 1'b0;
      drive(4'h0, 1, 0, 0, 4'd0, 0);
      model_reset();
      #12;
      check("reset_state", pack_dut(), 13'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].cnt, tbl[i].en, tbl[i].start,
               tbl[i].mode, tbl[i].rl, tbl[i].clr);
         step(0, "");
         check($sformatf("table_%0d", i), pack_dut(),
               {tbl[i].cout, tbl[i].b, tbl[i].t,
                tbl[i].d, tbl[i].s, tbl[i].y});
      end

      // Source frozen at 7: stall on the 8th equal sample.
      drive(4'h7, 1, 0, 1, 4'd3, 0);
      for (int i = 0; i < 9; i++) begin
         step(1, $sformatf("stall_seq_%0d", i));
         if (i == 7) check("stall_before", {12'h0, stall}, 13'h0);
      end
      check("stall_set", {12'h0, stall}, 13'h1);
      drive(4'h7, 1, 1, 1, 4'd3, 0);
      step(1, "stall_clear_start");
      check("stall_cleared", {12'h0, stall}, 13'h0);

      // Random traffic against the model.
      cur = 4'h9;
      hold_left = 0;
      for (int i = 0; i < 2500; i++) begin
         r = $urandom_range(0, 99);
         if (hold_left > 0) begin
            hold_left--;
         end else if (r < 2) begin
            hold_left = 10;
         end else if (r < 85) begin
            cur = cur - 4'd1;
         end else if (r < 93) begin
            cur = cur;
         end else begin
            cur = 4'($urandom_range(0, 15));
         end
         cnt_in    = cur;
         en        = ($urandom_range(0, 9) != 0);
         start     = ($urandom_range(0, 59) == 0);
         clr_done  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 99) == 0)
            mode_reload = ~mode_reload;
         if ($urandom_range(0, 19) == 0)
            reload_hi = 4'($urandom_range(0, 3));
         step(1, "random");
      end

      // Reset asserted mid-RUN, between edges.
      drive(4'h4, 1, 1, 0, 4'd5, 0);
      step(1, "pre_reset_start");
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_mid_run", pack_dut(), 13'h0);
      @(posedge clk);
      #1;
      check("reset_held", pack_dut(), 13'h0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      drive(4'h0, 1, 0, 0, 4'd0, 0);
      step(1, "post_reset_first");
      drive(4'hF, 1, 0, 0, 4'd0, 0);
      step(1, "post_reset_idle_wrap");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/down_cascade_stage.md
Name: down_cascade_stage

Overview:
- Downstream consumer of the 4-bit synchronous down counter.
- Samples its count every cycle and detects underflow wraps (0 -> F borrows).
- Extends the count with an HI_W-bit upper down counter and flags terminal count in one-shot or auto-reload mode.
- Flags a stalled (non-moving) source counter; feeds timer/interrupt logic.

Parameters:
HI_W, 4, width of the upper count; extended count is HI_W+4 bits.
STALL_CYC, 8, consecutive unchanged samples that set stall; 0 disables stall detection.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
cnt_in  input  4  count from the upstream down counter.
en  input  1  1 = borrows decrement the upper count; 0 = pause.
start  input  1  1-cycle pulse: load reload_hi, enter RUN.
mode_reload  input  1  1 = auto-reload on terminal count; 0 = one-shot.
reload_hi  input  HI_W  upper-count load value.
clr_done  input  1  clears the sticky done flag.
count_out  output  HI_W+4  extended count {hi_cnt, cnt_q}.
borrow  output  1  1-cycle pulse per detected wrap.
tc  output  1  1-cycle terminal-count pulse.
done  output  1  sticky; one-shot terminal count reached.
stall  output  1  sticky; source counter not moving.
busy  output  1  state == RUN.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi_cnt=0, cnt_q=0, valid_q=0, stall counter=0. All outputs 0: count_out, borrow, tc, done, stall, busy.
- Input sampling:
  - Every cycle, cnt_q <= cnt_in and valid_q <= 1.
  - The first sample after reset never produces a borrow (valid_q=0).
- Borrow detection:
  - borrow_det = valid_q && cnt_q==4'h0 && cnt_in==4'hF.
  - Any other jump (e.g. 5 -> 9, or an upstream reset to F from a nonzero value) is ignored.
- State IDLE:
  - Borrows ignored; hi_cnt holds.
  - start -> hi_cnt <= reload_hi, state RUN.
- State RUN, en=1, borrow_det:
  - borrow=1 on the next cycle.
  - If hi_cnt != 0: hi_cnt <= hi_cnt-1.
  - If hi_cnt == 0: terminal count; tc=1 on the next cycle, same cycle as borrow.
    - mode_reload=1: hi_cnt <= reload_hi, stay in RUN.
    - mode_reload=0: hi_cnt stays 0, state DONE, done <= 1.
- State RUN, en=0: cnt_q still tracks; no borrow, tc or decrement; stall counter holds.
- Latency: wrap visible on cnt_in at edge N -> borrow/tc/hi_cnt update at edge N+1 (one register stage).
- State DONE:
  - busy=0; borrows ignored; count_out = {0, cnt_q}.
  - start -> reload, done <= 0, state RUN.
- clr_done clears done in any state. start and clr_done together: start wins (done=0, RUN).
- start in RUN: immediate reload of hi_cnt; a coincident borrow_det is discarded (no borrow, no tc).
- Stall (STALL_CYC>0):
  - In RUN with en=1, the counter increments when cnt_in==cnt_q and clears when they differ.
  - Reaching STALL_CYC sets sticky stall (saturates, no wrap).
  - start clears stall and the counter.
- Arithmetic: hi_cnt is unsigned and never decrements below 0. reload_hi=0 in one-shot gives tc on the first borrow.
- Reset asserted mid-RUN: immediate return to all reset values; no tc is emitted.

Test Plan:
- Reset, HI_W=4, reload_hi=2, one-shot, start, source counts down F..0 repeatedly -> borrow at wraps 1, 2, 3. hi_cnt goes 2 -> 1 -> 0. tc and done=1 on wrap 3, state DONE, busy=0.
- Same setup with mode_reload=1 -> tc every 3rd wrap, hi_cnt reloads to 2, busy stays 1, done stays 0.
- en=0 for one full source period -> no borrow; hi_cnt unchanged. Re-enable -> decrements resume.
- Source jumps 3 -> F, and the first sample after reset is 0 followed by F -> no borrow in either case. A genuine 0 -> F gives exactly one borrow, one cycle later.
- cnt_in held at 7 for 8 cycles in RUN with STALL_CYC=8 -> stall=1 after the 8th equal sample. start -> stall=0.
- start coincident with 0 -> F wrap while in RUN -> hi_cnt = reload_hi, no borrow/tc pulse. rst low mid-RUN -> all outputs 0 asynchronously.
